retire_unit: RTL
================

// Module: retire_unit
// PURPOSE
//  In-order commit stage of the R10K core. Examines up to N ROB head entries each cycle and
//  retires the oldest contiguous run that has finished executing. Drives the T_old retire
//  interface of the free/complete list (phys_regs_retiring, num_retiring_valid) and pops the ROB.
//  Owns the architectural map table (arch reg -> phys reg), which is the recovery state for
//  exceptions and halts.
// PARAMETERS
//  N            `N                  retire width (ROB head entries examined per cycle)
//  PHYS_REGS    `PHYS_REG_SZ_R10K   physical register count (complete_list width)
//  ARCH_REGS    32                  architectural register count
// PORTS
//  clock               in   1                     core clock, all state on rising edge
//  reset               in   1                     synchronous, active-low (0 = reset)
//  rob_head_valid      in   N                     [i] = ROB entry head+i exists
//  rob_head_done       in   N                     [i] = entry head+i finished executing
//  rob_head_has_dest   in   N                     [i] = entry writes a register
//  rob_head_arch_dest  in   N x 5                 architectural destination
//  rob_head_T_new      in   N x PHYS_REG_IDX      newly mapped phys reg
//  rob_head_T_old      in   N x PHYS_REG_IDX      previous mapping, freed at retire
//  rob_head_halt       in   N                     [i] = entry is a halt instruction
//  complete_list       in   PHYS_REGS             from free/complete list; bit p = reg p written
//  phys_regs_retiring  out  N x PHYS_REG_IDX      packed T_old of retiring dest instrs
//  num_retiring_valid  out  NUM_SCALAR_BITS       valid slots in phys_regs_retiring (0..N)
//  num_rob_pop         out  NUM_SCALAR_BITS       ROB entries retired this cycle (0..N)
//  arch_map            out  ARCH_REGS x PHYS_REG_IDX  registered architectural map table
//  retired_count       out  32                    registered total instructions retired
//  halted              out  1                     registered; 1 once a halt retired
//  map_mismatch        out  1                     registered sticky error flag
// BEHAVIOUR
//  - Reset (reset==0 at a rising edge): arch_map[r]=r for all r; retired_count=0; halted=0;
//    map_mismatch=0; FSM -> RUN. While reset==0, all combinational outputs are forced to 0.
//  - Effective dest: eff_dest[i] = has_dest[i] && arch_dest[i]!=0 (r0 never remapped or freed).
//  - Ready: ready[i] = valid[i] && done[i] && (!eff_dest[i] || complete_list[T_new[i]]).
//  - Retire set: entry i retires iff ready[0..i] all true and no halt among entries 0..i-1.
//    Strictly in order; a non-ready entry blocks all younger ones even if they are ready.
//  - A halt entry retires (counted in num_rob_pop); nothing younger retires that cycle.
//  - Outputs are combinational, same cycle as the inputs; zero latency.
//    num_rob_pop = count of retiring entries. phys_regs_retiring[k] = T_old of the k-th
//    retiring eff_dest entry, oldest first. num_retiring_valid = number of such entries.
//    Unused slots are driven 0.
//  - The free/complete list samples phys_regs_retiring on the same edge. The ROB advances
//    its head by num_rob_pop on that edge.
//  - arch_map update (registered): for each retiring eff_dest entry, oldest to youngest,
//    arch_map[arch_dest]=T_new. The youngest write wins when two entries share an arch reg.
//  - Mismatch check: for each retiring eff_dest entry, T_old must equal the map value after
//    older same-cycle updates. Any violation sets map_mismatch=1 next cycle. The flag stays
//    set until reset. Retirement is not altered.
//  - retired_count += num_rob_pop each cycle, wrapping modulo 2^32.
//  - FSM: RUN -> HALTED on the edge where a halt retires. In HALTED, outputs are held at 0 and
//    nothing retires, while arch_map and retired_count keep their values. HALTED exits only
//    via reset. Reset mid-operation wins over any simultaneous retirement.
// TESTING
//  1 reset=0 two cycles -> arch_map[r]==r, all outputs 0, halted=0; reset=1, valid=0 -> pops 0.
//  2 N entries valid/done/dest, arch 1,2,3, T_new 40,41,42 complete, T_old 1,2,3 ->
//    num_rob_pop=3, num_retiring_valid=3, regs={1,2,3}; next cycle arch_map[1..3]=40..42.
//  3 entry0 ready, entry1 T_new not in complete_list, entry2 ready -> num_rob_pop=1, slot0 only.
//  4 entry0 store (has_dest=0), entry1 dest T_old=5 -> num_rob_pop=2, num_retiring_valid=1,
//    slot0=5.
//  5 entry0 arch4 T_new40 T_old4, entry1 arch4 T_new41 T_old40 -> arch_map[4]=41, no mismatch;
//    entry1 T_old=4 instead -> map_mismatch=1 sticky.
//  6 halt at entry1, entry2 ready -> num_rob_pop=2; halted=1 next cycle, later entries never
//    pop; reset=0 clears halted and map.

Source files
------------

// File: rtl/retire_unit.sv
// In-order commit stage: retires the oldest contiguous run of finished ROB head
// entries, frees their previous mappings and maintains the architectural map table.
module retire_unit #(
  parameter int unsigned N         = 3,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned ARCH_REGS = 32,
  localparam int unsigned PRI      = $clog2(PHYS_REGS),
  localparam int unsigned NSB      = $clog2(N + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N-1:0]             rob_head_valid,
  input  logic [N-1:0]             rob_head_done,
  input  logic [N-1:0]             rob_head_has_dest,
  input  logic [N*5-1:0]           rob_head_arch_dest,
  input  logic [N*PRI-1:0]         rob_head_T_new,
  input  logic [N*PRI-1:0]         rob_head_T_old,
  input  logic [N-1:0]             rob_head_halt,
  input  logic [PHYS_REGS-1:0]     complete_list,
  output logic [N*PRI-1:0]         phys_regs_retiring,
  output logic [NSB-1:0]           num_retiring_valid,
  output logic [NSB-1:0]           num_rob_pop,
  output logic [ARCH_REGS*PRI-1:0] arch_map,
  output logic [31:0]              retired_count,
  output logic                     halted,
  output logic                     map_mismatch
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]     state_q;
  logic [0:0]     state_d;
  logic [PRI-1:0] map_q [ARCH_REGS];
  logic [PRI-1:0] map_d [ARCH_REGS];
  logic [N-1:0]   eff_dest;
  logic [N-1:0]   ready;
  logic [N-1:0]   retire;
  logic           blocked;
  logic           mismatch_c;

  // Per-entry destination qualification and readiness (r0 is never renamed)
  for (genvar i = 0; i < N; i++) begin : g_entry
    assign eff_dest[i] = rob_head_has_dest[i] && (rob_head_arch_dest[i*5 +: 5] != 5'd0);
    assign ready[i]    = rob_head_valid[i] && rob_head_done[i] &&
                         (!eff_dest[i] || complete_list[rob_head_T_new[i*PRI +: PRI]]);
  end

  // Flatten the map table onto the output port
  for (genvar r = 0; r < ARCH_REGS; r++) begin : g_map_out
    assign arch_map[r*PRI +: PRI] = map_q[r];
  end

  // Retire selection, T_old packing, map update, mismatch check and next state
  always_comb begin
    state_d            = state_q;
    map_d              = map_q;
    retire             = '0;
    blocked            = 1'b0;
    mismatch_c         = 1'b0;
    phys_regs_retiring = '0;
    num_retiring_valid = '0;
    num_rob_pop        = '0;

    if (reset && (state_q == RUN)) begin
      for (int i = 0; i < N; i++) begin
        if (!blocked && ready[i]) begin
          retire[i]   = 1'b1;
          num_rob_pop = num_rob_pop + NSB'(1);
          if (rob_head_halt[i]) blocked = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end

      for (int i = 0; i < N; i++) begin
        if (retire[i] && eff_dest[i]) begin
          phys_regs_retiring[int'(num_retiring_valid)*PRI +: PRI] = rob_head_T_old[i*PRI +: PRI];
          num_retiring_valid = num_retiring_valid + NSB'(1);
          if (map_d[rob_head_arch_dest[i*5 +: 5]] != rob_head_T_old[i*PRI +: PRI])
            mismatch_c = 1'b1;
          map_d[rob_head_arch_dest[i*5 +: 5]] = rob_head_T_new[i*PRI +: PRI];
        end
      end

      if (|(retire & rob_head_halt)) state_d = HALTED;
    end
  end

  // State, map table and counters; reset overrides any retirement in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      retired_count <= '0;
      halted        <= 1'b0;
      map_mismatch  <= 1'b0;
      for (int r = 0; r < ARCH_REGS; r++) map_q[r] <= PRI'(r);
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      retired_count <= retired_count + 32'(num_rob_pop);
      halted        <= (state_d == HALTED);
      map_mismatch  <= map_mismatch | mismatch_c;
    end
  end

endmodule
